generador_refresco: RTL
=======================

# generador_refresco

Refresh-scan generator for the four-digit seven-segment display. It divides the system clock into a per-digit scan tick and produces the 2-bit digit select `refrescamiento_o` consumed by the anode/cathode control stage. It also presents the 4-bit nibble for the currently selected digit to the segment decoder. The display value is double-buffered and committed only at frame boundaries, so a digit never shows a half-updated number.

## Interface
- `DIV`, default 100_000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range 1..2^24
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `enable_i`  in  1  scan enable; low freezes the scan
- `valor_i`  in  16  display value, nibble k = digit k (k=0 rightmost)
- `valor_valid_i`  in  1  single-cycle strobe capturing `valor_i`
- `refrescamiento_o`  out  2  current digit select, 0 = rightmost
- `digito_o`  out  4  nibble of the committed value at index `refrescamiento_o`
- `blank_o`  out  1  current digit must be blanked (see Configuration)
- `tick_o`  out  1  one-cycle pulse at the end of each digit slot
- `frame_o`  out  1  one-cycle pulse at the end of digit 3's slot (frame boundary)

## Operation
- Prescaler `cnt`, width clog2(DIV) (min 1), counts 0..DIV-1 while `enable_i`=1 and wraps to 0. `tick_o` = `enable_i` && (`cnt`==DIV-1), decoded combinationally from registers.
- On a clock edge with `tick_o`=1, `sel` increments mod 4 (3 -> 0 wraps).
- `frame_o` = `tick_o` && (`sel`==3).
- Two 16-bit registers:
  - `pend` loads `valor_i` on any cycle with `valor_valid_i`=1; the last strobe wins.
  - `valor_q` loads at a frame boundary (edge with `frame_o`=1). If `valor_valid_i`=1 on that same edge, `valor_i` is committed directly (bypass), not the old `pend`.
- `digito_o` = `valor_q[4*sel +: 4]`, combinational from registers.
- `enable_i`=0: `cnt` and `sel` hold; `tick_o`/`frame_o` are 0. `pend` capture still works. `valor_q` does not update.
- DIV=1: `tick_o` stays high while enabled, and `sel` advances every cycle.
- Reset (async assert, sync-safe release): `cnt`=0, `sel`=0, `pend`=0, `valor_q`=0. Outputs: `refrescamiento_o`=0, `digito_o`=0, `blank_o`=0, `tick_o`=0, `frame_o`=0. Reset mid-frame discards the pending value.

## Timing
- After reset release with `enable_i`=1, the first `tick_o` occurs in cycle DIV (cycles numbered from 1 at the first enabled edge). `refrescamiento_o` becomes 1 in cycle DIV+1.
- `refrescamiento_o` changes exactly on the edge that ends a `tick_o` cycle, coincident with `cnt` returning to 0.
- Full frame = 4*DIV enabled cycles.
- Latency from `valor_valid_i` to `digito_o`: the value appears in the first cycle after the next frame boundary, i.e. when `refrescamiento_o`=0. The worst case is 4*DIV cycles.
- `digito_o` and `blank_o` change in the same cycle as `refrescamiento_o`. There is no extra pipeline stage.

## Configuration
- `GENERADOR_REFRESCO_BLANK_EN` defined: leading-zero blanking is enabled.
  - `blank_o`=1 when `sel`=k>0 and `valor_q` nibbles k..3 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - `blank_o` derives from `valor_q`, not `pend`.
- Macro undefined: `blank_o` is tied 0 and no blanking logic is synthesized.

## Structure
- Package `display_pkg`:
  - `N_DIGITOS`=4, `SEL_W`=2, `NIBBLE_W`=4
  - `typedef logic [SEL_W-1:0] sel_t`
  - `typedef logic [N_DIGITOS*NIBBLE_W-1:0] valor_t`
- Sub-module `divisor_tick`: parameter DIV; ports `clk`, `rst_n`, `enable_i`, `tick_o`. It holds the prescaler counter.
- The top holds `sel`, `pend`, `valor_q`, the nibble mux and the blanking logic.

## Test plan
- DIV=4, `enable_i`=1 after reset: `tick_o` pulses in cycles 4, 8, 12, 16. `refrescamiento_o` steps 0,1,2,3,0. `frame_o` pulses only in cycle 16.
- Strobe `valor_i`=16'h1234 in cycle 5: `digito_o` stays 0 until cycle 17. From cycle 17, `digito_o` = 4,3,2,1 over consecutive 4-cycle slots.
- Strobe 16'hAAAA in cycle 10, then 16'h5555 in cycle 16 (a frame edge): the bypass commits 16'h5555. Every digit reads 5 in the next frame.
- Deassert `enable_i` for 7 cycles mid-slot: `cnt`, `refrescamiento_o` and `digito_o` hold, with no `tick_o`. The slot resumes and completes with its remaining count.
- `GENERADOR_REFRESCO_BLANK_EN` with value 16'h0070: `blank_o`=0,0,1,1 for sel 0..3. With value 16'h0000: `blank_o`=0,1,1,1. With the macro undefined, `blank_o`=0 throughout.
- Assert `rst_n`=0 asynchronously mid-slot with sel=2 and `valor_q`=16'h1234: all outputs are 0 immediately. After release, scanning restarts from sel 0 showing 0.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared widths and types for the seven-segment refresh scan
package display_pkg;
  localparam int N_DIGITOS = 4;
  localparam int SEL_W = 2;
  localparam int NIBBLE_W = 4;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_DIGITOS*NIBBLE_W-1:0] valor_t;
endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: prescaler emitting a one-cycle tick every DIV enabled cycles
module divisor_tick #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic tick_o
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  // count 0..DIV-1 while enabled, hold otherwise
  always_comb begin
    tick_o = enable_i && (cnt_q == CW'(DIV - 1));
    cnt_d  = !enable_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
  end
  // prescaler register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/generador_refresco.sv
// generador_refresco: four-digit refresh scan with frame-aligned double-buffered value
// Optional leading-zero blanking: define GENERADOR_REFRESCO_BLANK_EN
module generador_refresco
  import display_pkg::*;
#(
  parameter int DIV = 100_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic [N_DIGITOS*NIBBLE_W-1:0] valor_i,
  input  logic                          valor_valid_i,
  output logic [SEL_W-1:0]              refrescamiento_o,
  output logic [NIBBLE_W-1:0]           digito_o,
  output logic                          blank_o,
  output logic                          tick_o,
  output logic                          frame_o
);
  sel_t   sel_q, sel_d;
  valor_t pend_q, pend_d, valor_q, valor_d;
  divisor_tick #(.DIV(DIV)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable_i),
    .tick_o   (tick_o)
  );
  // advance digit on tick; commit value at frame end, a same-edge strobe bypasses pend
  always_comb begin
    frame_o = tick_o && (sel_q == sel_t'(N_DIGITOS - 1));
    sel_d   = tick_o ? sel_q + 1'b1 : sel_q;
    pend_d  = valor_valid_i ? valor_i : pend_q;
    valor_d = !frame_o ? valor_q : valor_valid_i ? valor_i : pend_q;
  end
  // scan and buffer registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel_q   <= '0;
      pend_q  <= '0;
      valor_q <= '0;
    end else begin
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      valor_q <= valor_d;
    end
  assign refrescamiento_o = sel_q;
  assign digito_o         = valor_q[NIBBLE_W*sel_q +: NIBBLE_W];
`ifdef GENERADOR_REFRESCO_BLANK_EN
  logic [N_DIGITOS-1:1] z;
  for (genvar k = 1; k < N_DIGITOS; k++) begin : g_z
    assign z[k] = valor_q[NIBBLE_W*k +: NIBBLE_W] == '0;
  end
  // blank a digit when it and every more-significant nibble are zero; digit 0 always shows
  always_comb
    blank_o = sel_q == 2'd1 ? &z[3:1] : sel_q == 2'd2 ? &z[3:2] : sel_q == 2'd3 ? z[3] : 1'b0;
`else
  assign blank_o = 1'b0;
`endif
endmodule
